jk_mod_counter: RTL and testbench
=================================

Name: jk_mod_counter

Overview:
- Synchronous modulo-N up/down counter built from a bank of JK flip-flop cells.
- Per-bit excitation logic drives each cell's J/K from the desired next state.
- Used as the next stage up from single JK flip-flops, wherever the design needs a structural JK counter: dividers, sequencers, event counters.
- Provides enable, direction, parallel load, terminal-count and out-of-range-load indication.

Parameters:
- WIDTH, 4, counter width in bits; must be ≥1.
- MODULUS, 16, count range 0..MODULUS-1; must satisfy 2 ≤ MODULUS ≤ 2^WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  parallel load strobe.
- d  input  WIDTH  parallel load value.
- q  output  WIDTH  count value, registered in the JK cells.
- qn  output  WIDTH  bitwise inverse of q, registered in the JK cells.
- tc  output  1  terminal count, combinational.
- ovr  output  1  out-of-range load flag, registered one-cycle pulse.

Behaviour:
- Single clock domain. All state changes occur on rising clk only. Reset is synchronous and active-high.
- Priority each edge: rst > load > en > hold.
- Reset values: q=0, qn=all ones, ovr=0. tc follows its equation with q=0.
- Next-state rules:
  - load=1, d<MODULUS: next=d.
  - load=1, d≥MODULUS: next=0 and ovr=1 for exactly the following cycle.
  - en=1, up=1: next = (q==MODULUS-1) ? 0 : q+1.
  - en=1, up=0: next = (q==0) ? MODULUS-1 : q-1.
  - Otherwise: next=q (all cells J=K=0).
- Excitation per bit i, from cur=q[i] and nxt=next[i]:
  - J = nxt & ~cur
  - K = ~nxt & cur
  - Only codes HOLD, SET and RESET are generated. TOGGLE is never issued by the counter.
- Latency: q reflects a load or count one cycle after the sampling edge. qn == ~q at all times after the first reset.
- tc = en & ~load & ((up & q==MODULUS-1) | (~up & q==0)). It is high in the cycle before a wrap edge.
- ovr is cleared on every edge where the out-of-range-load condition does not occur.
- Arithmetic is WIDTH bits wide. The compare against MODULUS uses WIDTH+1 bits so MODULUS=2^WIDTH is legal.
- Boundary conditions:
  - Simultaneous load and en: load wins, no count that cycle.
  - rst asserted mid-count or together with load: q=0 next edge, ovr=0.
  - en toggled between cycles: no glitch, counts only on edges with en=1.
  - q is never observable ≥ MODULUS.

Optional Feature:
- Macro: JK_MOD_COUNTER_SAT_EN.
- Defined:
  - Counter saturates. up at MODULUS-1 holds MODULUS-1; down at 0 holds 0.
  - tc still asserts under the same equation, marking the saturated condition.
  - Load behaviour unchanged.
- Undefined: wrap-around behaviour as in Behaviour.

Decomposition:
- Shared package jk_pkg holds:
  - JK code constants: JK_HOLD=2'b00, JK_RESET=2'b01, JK_SET=2'b10, JK_TOGGLE=2'b11.
  - Function jk_excite(cur, nxt) returning the 2-bit {J,K}.
- Sub-module jk_cell:
  - One-bit JK flip-flop with synchronous active-high rst.
  - Outputs Q and Qn; reset gives Q=0, Qn=1.
  - Instantiated WIDTH times via generate.
- Top level contains next-state logic, excitation, tc and the ovr register.

Test Plan (WIDTH=4, MODULUS=10):
- Reset: rst=1 for 2 cycles with en=1, up=1 -> q=0, qn=4'hF, ovr=0. After release q stays 0 until en is sampled.
- Up count: en=1, up=1 for 12 cycles from 0 -> q sequence 1..9,0,1,2. tc=1 only in the cycle q=9.
- Down count: q=0, en=1, up=0 -> q=9 next, then 8, 7. tc=1 in the q=0 cycle. With SAT_EN defined, q stays 0 and in the up test stays 9.
- Load priority: q=3, load=1, d=7, en=1 -> q=7 next cycle, tc=0 during the load cycle, ovr=0.
- Out-of-range load: load=1, d=12 -> q=0, ovr=1 for exactly one cycle, then ovr=0.
- Reset mid-operation: q=5, en=1, load=1, d=2, rst=1 same edge -> q=0, qn=4'hF. Checker asserts qn==~q every cycle and J/K never equals JK_TOGGLE.

Source files
------------

// File: rtl/jk_pkg.sv
// JK flip-flop excitation codes and the helper that maps (current, next)
// state to the {J,K} pair that produces the transition.
package jk_pkg;

  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  // Returns {J,K}. Only HOLD, SET or RESET can result, never TOGGLE.
  function automatic logic [1:0] jk_excite(input logic cur, input logic nxt);
    return {nxt & ~cur, ~nxt & cur};
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with synchronous active-high reset and registered
// true/complement outputs.
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qn
);

  logic q_q;
  logic qn_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q  <= 1'b0;
      qn_q <= 1'b1;
    end else begin
      case ({j, k})
        JK_SET: begin
          q_q  <= 1'b1;
          qn_q <= 1'b0;
        end
        JK_RESET: begin
          q_q  <= 1'b0;
          qn_q <= 1'b1;
        end
        JK_TOGGLE: begin
          q_q  <= ~q_q;
          qn_q <= ~qn_q;
        end
        JK_HOLD: begin
          q_q  <= q_q;
          qn_q <= qn_q;
        end
        default: begin
          q_q  <= q_q;
          qn_q <= qn_q;
        end
      endcase
    end
  end

  assign q  = q_q;
  assign qn = qn_q;

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-MODULUS up/down counter built from a bank of JK cells.
// Define JK_MOD_COUNTER_SAT_EN to saturate at the range ends instead of wrapping.
module jk_mod_counter
  import jk_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             tc,
  output logic             ovr
);

  // Compared one bit wider so MODULUS == 2**WIDTH is representable.
  localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic [WIDTH-1:0] nxt_d;
  logic [WIDTH-1:0] j_w;
  logic [WIDTH-1:0] k_w;
  logic             at_max;
  logic             at_min;
  logic             ovr_d;
  logic             ovr_q;

  assign at_max = (q == MAX_Q);
  assign at_min = (q == '0);

  always_comb begin
    nxt_d = q;
    ovr_d = 1'b0;
    if (load) begin
      if ({1'b0, d} < MOD_X) begin
        nxt_d = d;
      end else begin
        nxt_d = '0;
        ovr_d = 1'b1;
      end
    end else if (en) begin
      if (up) begin
`ifdef JK_MOD_COUNTER_SAT_EN
        nxt_d = at_max ? MAX_Q : q + ONE;
`else
        nxt_d = at_max ? '0 : q + ONE;
`endif
      end else begin
`ifdef JK_MOD_COUNTER_SAT_EN
        nxt_d = at_min ? '0 : q - ONE;
`else
        nxt_d = at_min ? MAX_Q : q - ONE;
`endif
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign {j_w[i], k_w[i]} = jk_excite(q[i], nxt_d[i]);

    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .j   (j_w[i]),
      .k   (k_w[i]),
      .q   (q[i]),
      .qn  (qn[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_q <= 1'b0;
    end else begin
      ovr_q <= ovr_d;
    end
  end

  assign ovr = ovr_q;
  assign tc  = en & ~load & ((up & at_max) | (~up & at_min));

endmodule

// File: tb/tb_jk_mod_counter.sv
// Scoreboard bench for jk_mod_counter (WIDTH=4, MODULUS=10), wrap or saturate build.
module tb_jk_mod_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       up = 1'b0;
  logic       load = 1'b0;
  logic [3:0] d = '0;
  logic [3:0] q;
  logic [3:0] qn;
  logic       tc;
  logic       ovr;

  jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .up   (up),
    .load (load),
    .d    (d),
    .q    (q),
    .qn   (qn),
    .tc   (tc),
    .ovr  (ovr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] q;
    logic       tc;
    logic       ovr;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;
  bit   started = 1'b0;

`ifdef JK_MOD_COUNTER_SAT_EN
  int up_q[12]  = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 9, 9};
  int dn_q[4]   = '{0, 0, 0, 0};
  int dn_tc[4]  = '{1, 1, 1, 1};
  int after_up  = 9;
  int after_dn  = 0;
  int after_max = 9;
`else
  int up_q[12]  = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};
  int dn_q[4]   = '{0, 9, 8, 7};
  int dn_tc[4]  = '{1, 0, 0, 0};
  int after_up  = 2;
  int after_dn  = 6;
  int after_max = 0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Apply one cycle of inputs and queue the outputs expected while they are held.
  task automatic vec(input logic r, input logic e, input logic u, input logic l,
                     input logic [3:0] dv, input int eq, input logic etc, input logic eovr);
    exp_t x;
    rst = r; en = e; up = u; load = l; d = dv;
    x.q = 4'(eq); x.tc = etc; x.ovr = eovr;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("qn_inv_q", {28'd0, qn}, {28'd0, ~q});
      chk("no_toggle", {31'd0, |(dut.j_w & dut.k_w)}, 32'd0);
    end
    if (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      chk("q",   {28'd0, q},   {28'd0, x.q});
      chk("qn",  {28'd0, qn},  {28'd0, ~x.q});
      chk("tc",  {31'd0, tc},  {31'd0, x.tc});
      chk("ovr", {31'd0, ovr}, {31'd0, x.ovr});
    end
  end

  initial begin
    rst = 1'b1; en = 1'b1; up = 1'b1;
    @(posedge clk);
    #1;
    started = 1'b1;
    // second reset cycle, then idle: q must stay 0
    vec(1, 1, 1, 0, 4'd0, 0, 0, 0);
    vec(0, 0, 1, 0, 4'd0, 0, 0, 0);
    vec(0, 0, 1, 0, 4'd0, 0, 0, 0);
    // up count
    for (int k = 0; k < 12; k++)
      vec(0, 1, 1, 0, 4'd0, up_q[k], (up_q[k] == 9), 0);
    // load 0, then down count
    vec(0, 0, 0, 1, 4'd0, after_up, 0, 0);
    for (int k = 0; k < 4; k++)
      vec(0, 1, 0, 0, 4'd0, dn_q[k], dn_tc[k][0], 0);
    // load priority over en
    vec(0, 0, 1, 1, 4'd3, after_dn, 0, 0);
    vec(0, 1, 1, 1, 4'd7, 3, 0, 0);
    vec(0, 0, 1, 0, 4'd0, 7, 0, 0);
    // out-of-range load d=12
    vec(0, 0, 1, 1, 4'd12, 7, 0, 0);
    vec(0, 0, 1, 0, 4'd0, 0, 0, 1);
    vec(0, 0, 1, 0, 4'd0, 0, 0, 0);
    // boundary loads: 9 legal, 10 out of range
    vec(0, 1, 1, 1, 4'd9, 0, 0, 0);
    vec(0, 0, 1, 0, 4'd0, 9, 0, 0);
    vec(0, 1, 1, 0, 4'd0, 9, 1, 0);
    vec(0, 0, 1, 1, 4'd10, after_max, 0, 0);
    vec(0, 0, 1, 0, 4'd0, 0, 0, 1);
    vec(0, 0, 1, 0, 4'd0, 0, 0, 0);
    // reset together with load and en at q=5
    vec(0, 0, 1, 1, 4'd5, 0, 0, 0);
    vec(0, 0, 1, 0, 4'd0, 5, 0, 0);
    vec(1, 1, 1, 1, 4'd2, 5, 0, 0);
    vec(0, 0, 1, 0, 4'd0, 0, 0, 0);
    // reset clears a pending ovr pulse
    vec(0, 0, 1, 1, 4'd14, 0, 0, 0);
    vec(1, 0, 1, 0, 4'd0, 0, 0, 1);
    vec(0, 0, 1, 0, 4'd0, 0, 0, 0);
    // drain scoreboard with a bounded wait
    for (int k = 0; k < 5 && sb.size() > 0; k++) @(posedge clk);
    #6;
    n_total++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL drain: %0d entries left, expected 0", sb.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
